// File: rtl/seq10110_pkg.sv
// Shared constants for the 10110 stimulus generator: the target pattern and the FSM encoding.
package seq10110_pkg;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/seq10110_window.sv
// Sliding history of the transmitted stream, Mealy pattern compare and saturating match counter.
module seq10110_window
  import seq10110_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic             bit_i,
  output logic             exp_match_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  logic [PAT_LEN-2:0] hist_q;
  logic [CNT_W-1:0]   cnt_q;

  // The bit currently on the line completes the window, so the compare is combinational.
  assign exp_match_o = valid_i && ({hist_q, bit_i} == PATTERN);
  assign match_cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (valid_i) begin
        hist_q <= {hist_q[PAT_LEN-3:0], bit_i};
      end
      if (exp_match_o && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq10110_gen.sv
// Serial stimulus transmitter for the 10110 detector: load/ready handshake, LSB-first shifting
// of a word replayed reps+1 times, plus the expected-match reference stream.
module seq10110_gen
  import seq10110_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REP_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [REP_W-1:0] reps_i,
  output logic             ready_o,
  output logic             outp_o,
  output logic             valid_o,
  output logic             exp_match_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             done_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] savedWord_q, savedWord_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic [REP_W-1:0] repLeft_q, repLeft_d;
  logic             done_q, done_d;
  logic             accept;
  logic             lastBit;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == SHIFT);
  assign outp_o  = valid_o & shreg_q[0];
  assign done_o  = done_q;
  assign accept  = ready_o & load_i;
  assign lastBit = (bitIdx_q == IDX_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    savedWord_d = savedWord_q;
    bitIdx_d    = bitIdx_q;
    repLeft_d   = repLeft_q;
    done_d      = 1'b0;
    if (state_q == IDLE) begin
      if (load_i) begin
        state_d     = SHIFT;
        shreg_d     = data_i;
        savedWord_d = data_i;
        repLeft_d   = reps_i;
        bitIdx_d    = '0;
      end
    end else begin
      shreg_d  = shreg_q >> 1;
      bitIdx_d = bitIdx_q + 1'b1;
      // A replay keeps the history window intact so boundary-spanning matches still count.
      if (lastBit) begin
        if (repLeft_q != '0) begin
          shreg_d   = savedWord_q;
          repLeft_d = repLeft_q - 1'b1;
          bitIdx_d  = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      savedWord_q <= '0;
      bitIdx_q    <= '0;
      repLeft_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      savedWord_q <= savedWord_d;
      bitIdx_q    <= bitIdx_d;
      repLeft_q   <= repLeft_d;
      done_q      <= done_d;
    end
  end

  seq10110_window #(
    .CNT_W(CNT_W)
  ) u_window (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .valid_i    (valid_o),
    .bit_i      (outp_o),
    .exp_match_o(exp_match_o),
    .match_cnt_o(match_cnt_o)
  );

endmodule

// File: tb/tb_seq10110_gen.sv
// Self-checking bench for seq10110_gen: directed scenarios plus random words, each checked
// cycle-by-cycle against a stream/pattern model built from the word, the repeat count and 10110.
module tb_seq10110_gen;

  localparam int WIDTH = 16;
  localparam int REP_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [REP_W-1:0] reps = '0;
  logic             ready;
  logic             outp;
  logic             valid;
  logic             expMatch;
  logic [CNT_W-1:0] matchCnt;
  logic             done;

  int checks = 0;
  int failures = 0;

  seq10110_gen #(
    .WIDTH(WIDTH),
    .REP_W(REP_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .data_i     (data),
    .reps_i     (reps),
    .ready_o    (ready),
    .outp_o     (outp),
    .valid_o    (valid),
    .exp_match_o(expMatch),
    .match_cnt_o(matchCnt),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] d,
                               input logic [REP_W-1:0] r);
    load = l;
    data = d;
    reps = r;
  endtask

  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_outp"}, 32'(outp), 32'd0);
    checkOutput({tag, "_match"}, 32'(expMatch), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge of the done cycle.
  task automatic runWord(input string tag, input logic [WIDTH-1:0] d,
                         input logic [REP_W-1:0] r, input bit noisy,
                         output int finalCnt);
    logic stream[$];
    int   total;
    int   cnt;
    bit   m;
    checkOutput({tag, "_ready_pre"}, 32'(ready), 32'd1);
    applyStimulus(1'b1, d, r);
    @(negedge clk);
    applyStimulus(1'b0, WIDTH'($urandom), REP_W'($urandom));
    for (int p = 0; p <= int'(r); p++)
      for (int k = 0; k < WIDTH; k++) stream.push_back(d[k]);
    total = stream.size();
    cnt = 0;
    for (int n = 0; n < total; n++) begin
      m = (n >= 4) && stream[n-4] && !stream[n-3] && stream[n-2] && stream[n-1] && !stream[n];
      checkOutput($sformatf("%s_outp[%0d]", tag, n), 32'(outp), 32'(stream[n]));
      checkOutput($sformatf("%s_valid[%0d]", tag, n), 32'(valid), 32'd1);
      checkOutput($sformatf("%s_ready[%0d]", tag, n), 32'(ready), 32'd0);
      checkOutput($sformatf("%s_done[%0d]", tag, n), 32'(done), 32'd0);
      checkOutput($sformatf("%s_match[%0d]", tag, n), 32'(expMatch), 32'(m));
      checkOutput($sformatf("%s_cnt[%0d]", tag, n), 32'(matchCnt), 32'(cnt));
      if (m && cnt < (1 << CNT_W) - 1) cnt++;
      if (noisy) applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), REP_W'($urandom));
      @(negedge clk);
    end
    applyStimulus(1'b0, data, reps);
    checkIdle({tag, "_end"}, 1'b1);
    checkOutput({tag, "_cnt_end"}, 32'(matchCnt), 32'(cnt));
    finalCnt = cnt;
  endtask

  initial begin
    int c;
    logic [WIDTH-1:0] w;
    logic [REP_W-1:0] rr;

    // Reset state
    rst = 1'b0;
    #12;
    checkIdle("reset", 1'b0);
    checkOutput("reset_cnt", 32'(matchCnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkIdle("idle0", 1'b0);

    // Scenario 1 and 2: overlapping pattern, single pass then two passes
    runWord("t1", 16'b1011011011011011, 4'd0, 1'b0, c);
    checkOutput("t1_total", 32'(c), 32'd4);
    @(negedge clk);
    checkIdle("t1_after", 1'b0);
    runWord("t2", 16'b1011011011011011, 4'd1, 1'b0, c);
    checkOutput("t2_total", 32'(c), 32'd8);
    @(negedge clk);

    // Scenario 3: single match at index 4
    runWord("t3", 16'h000D, 4'd0, 1'b0, c);
    checkOutput("t3_total", 32'(c), 32'd1);
    @(negedge clk);

    // Scenario 4: 256 zero bits with ignored load pulses and churning data
    runWord("t4", 16'h0000, 4'd15, 1'b1, c);
    checkOutput("t4_total", 32'(c), 32'd0);
    @(negedge clk);

    // Scenario 5: asynchronous reset at bit 7
    applyStimulus(1'b1, 16'b1011011011011011, 4'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'hFFFF, 4'd0);
    repeat (7) @(negedge clk);
    checkOutput("t5_bit7", 32'(outp), 32'd1);
    checkOutput("t5_cnt_pre", 32'(matchCnt), 32'd1);
    rst = 1'b0;
    #1;
    checkIdle("t5_rst", 1'b0);
    checkOutput("t5_rst_cnt", 32'(matchCnt), 32'd0);
    @(negedge clk);
    checkIdle("t5_hold", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    runWord("t5_new", 16'h000D, 4'd0, 1'b0, c);
    checkOutput("t5_total", 32'(c), 32'd1);
    @(negedge clk);

    // Scenario 6: load held through done gives back-to-back words
    runWord("t6a", 16'b1011011011011011, 4'd0, 1'b0, c);
    runWord("t6b", 16'h000D, 4'd0, 1'b0, c);
    checkOutput("t6_total", 32'(c), 32'd1);
    @(negedge clk);

    // Random words, random replay counts, random chaining and noise
    for (int i = 0; i < 8; i++) begin
      w  = WIDTH'($urandom);
      rr = REP_W'($urandom_range(0, 3));
      runWord($sformatf("rnd%0d", i), w, rr, bit'($urandom_range(0, 1)), c);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
